pipe_front_regs: RTL and testbench

- Sequential consumer of the stall/bubble enables from the decode-stage hazard detector.
- Owns the PC register, the IF/ID pipeline register and the ID/EX pipeline register.
- Applies the PC hold, IF/ID hold and ID/EX bubble decisions, plus branch flush.
- Runs the halt drain state machine that raises `halted` once a halt opcode has retired.

---
 rtl/pipe_front_regs.sv | 182 ++++++++++++++++++
 tb/tb_pipe_front_regs.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_front_regs.sv
`default_nettype none
// ============================================================================
// Module   : pipe_front_regs
// Brief    : PC, IF/ID and ID/EX registers with stall/bubble/flush handling
//            and the halt drain state machine.
//            Optional macro PIPE_STALL_STATS_EN adds stall/bubble counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_front_regs #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          CTRL_W       = 16,
    parameter int          DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hazardPCenable,
    input  logic              hazardIFIDenable,
    input  logic              hazardIDEXenable,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    input  logic [31:0]       F_instruction,
    input  logic [CTRL_W-1:0] D_ctrl,
    input  logic [4:0]        D_rt,
    input  logic              D_MemRead,
    output logic [31:0]       PC,
    output logic [31:0]       D_instruction,
    output logic [31:0]       D_pc_plus4,
    output logic              D_valid,
    output logic [CTRL_W-1:0] X_ctrl,
    output logic [4:0]        X_rt,
    output logic              X_MemRead,
    output logic              X_valid,
    output logic              halted
`ifdef PIPE_STALL_STATS_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       bubble_count
`endif
);

    localparam logic [1:0] c_ST_RUN    = 2'd0;
    localparam logic [1:0] c_ST_DRAIN  = 2'd1;
    localparam logic [1:0] c_ST_HALTED = 2'd2;
    localparam logic [5:0] c_HALT_OP   = 6'h3f;
    localparam logic [3:0] c_DRAIN_LD  = 4'(DRAIN_CYCLES - 1);

    logic [1:0]        r_state;
    logic [3:0]        r_drain_cnt;
    logic              r_halted;
    logic [31:0]       r_pc;
    logic [31:0]       r_d_inst;
    logic [31:0]       r_d_pc4;
    logic              r_d_valid;
    logic [CTRL_W-1:0] r_x_ctrl;
    logic [4:0]        r_x_rt;
    logic              r_x_memread;
    logic              r_x_valid;

    logic              w_frozen;
    logic              w_bubble;
    logic [31:0]       w_pc_plus4;
    logic              w_halt_in_d;

    assign w_frozen    = (r_state == c_ST_HALTED);
    assign w_bubble    = w_frozen || branch_taken || hazardIDEXenable;
    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_halt_in_d = r_d_valid && (r_d_inst[31:26] == c_HALT_OP);

    // Fetch side: branch redirect outranks the hazard unit's hold request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_d_inst  <= 32'd0;
            r_d_pc4   <= 32'd0;
            r_d_valid <= 1'b0;
        end else if (!w_frozen) begin
            if (branch_taken) begin
                r_pc <= branch_target;
            end else if (hazardPCenable) begin
                r_pc <= w_pc_plus4;
            end

            if (branch_taken) begin
                r_d_inst  <= 32'd0;
                r_d_pc4   <= 32'd0;
                r_d_valid <= 1'b0;
            end else if (hazardIFIDenable) begin
                r_d_inst  <= F_instruction;
                r_d_pc4   <= w_pc_plus4;
                r_d_valid <= 1'b1;
            end
        end
    end

    // A bubble clears X_MemRead too, so a stale X_rt cannot re-trigger a load-use stall.
    always_ff @(posedge clk) begin
        if (reset || w_bubble) begin
            r_x_ctrl    <= '0;
            r_x_rt      <= 5'd0;
            r_x_memread <= 1'b0;
            r_x_valid   <= 1'b0;
        end else begin
            r_x_ctrl    <= D_ctrl;
            r_x_rt      <= D_rt;
            r_x_memread <= D_MemRead;
            r_x_valid   <= r_d_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_RUN;
            r_drain_cnt <= 4'd0;
            r_halted    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    if (w_halt_in_d && !branch_taken) begin
                        r_state     <= c_ST_DRAIN;
                        r_drain_cnt <= c_DRAIN_LD;
                    end
                end
                c_ST_DRAIN: begin
                    // A branch resolving behind the halt means the halt was wrong-path.
                    if (branch_taken) begin
                        r_state     <= c_ST_RUN;
                        r_drain_cnt <= 4'd0;
                    end else if (r_drain_cnt == 4'd0) begin
                        r_state  <= c_ST_HALTED;
                        r_halted <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 4'd1;
                    end
                end
                c_ST_HALTED: begin
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state     <= c_ST_RUN;
                    r_drain_cnt <= 4'd0;
                end
            endcase
        end
    end

`ifdef PIPE_STALL_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_bubble_count;
    logic        w_stats_live;

    assign w_stats_live = !w_frozen && !branch_taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= 32'd0;
            r_bubble_count <= 32'd0;
        end else if (w_stats_live) begin
            if (!hazardPCenable && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (hazardIDEXenable && (r_bubble_count != 32'hFFFF_FFFF)) begin
                r_bubble_count <= r_bubble_count + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign bubble_count = r_bubble_count;
`endif

    assign PC            = r_pc;
    assign D_instruction = r_d_inst;
    assign D_pc_plus4    = r_d_pc4;
    assign D_valid       = r_d_valid;
    assign X_ctrl        = r_x_ctrl;
    assign X_rt          = r_x_rt;
    assign X_MemRead     = r_x_memread;
    assign X_valid       = r_x_valid;
    assign halted        = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_pipe_front_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_front_regs
// Brief    : Self-checking bench for pipe_front_regs (vector table, directed
//            corner cases and randomized traffic against a behavioural model).
//            Honours PIPE_STALL_STATS_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_front_regs;

    localparam int          CTRL_W       = 16;
    localparam int          DRAIN_CYCLES = 3;
    localparam logic [31:0] RESET_PC     = 32'h0000_0000;
    localparam logic [31:0] HALT_I       = 32'hFC00_0000;

    logic              clk = 1'b0;
    logic              reset, hazardPCenable, hazardIFIDenable, hazardIDEXenable;
    logic              branch_taken, D_MemRead;
    logic [31:0]       branch_target, F_instruction;
    logic [CTRL_W-1:0] D_ctrl;
    logic [4:0]        D_rt;
    logic [31:0]       PC, D_instruction, D_pc_plus4;
    logic              D_valid, X_MemRead, X_valid, halted;
    logic [CTRL_W-1:0] X_ctrl;
    logic [4:0]        X_rt;
`ifdef PIPE_STALL_STATS_EN
    logic [31:0]       stall_cycles, bubble_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_front_regs #(
        .RESET_PC    (RESET_PC),
        .CTRL_W      (CTRL_W),
        .DRAIN_CYCLES(DRAIN_CYCLES)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .hazardPCenable  (hazardPCenable),
        .hazardIFIDenable(hazardIFIDenable),
        .hazardIDEXenable(hazardIDEXenable),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .F_instruction   (F_instruction),
        .D_ctrl          (D_ctrl),
        .D_rt            (D_rt),
        .D_MemRead       (D_MemRead),
        .PC              (PC),
        .D_instruction   (D_instruction),
        .D_pc_plus4      (D_pc_plus4),
        .D_valid         (D_valid),
        .X_ctrl          (X_ctrl),
        .X_rt            (X_rt),
        .X_MemRead       (X_MemRead),
        .X_valid         (X_valid),
        .halted          (halted)
`ifdef PIPE_STALL_STATS_EN
        ,
        .stall_cycles    (stall_cycles),
        .bubble_count    (bubble_count)
`endif
    );

    // Behavioural model: mode 0 = running, 1 = draining, 2 = halted.
    logic [31:0]       m_pc, m_dinst, m_dpc4;
    logic              m_dv, m_xmr, m_xv;
    logic [CTRL_W-1:0] m_xctrl;
    logic [4:0]        m_xrt;
    int                m_mode, m_left;
    longint            m_stall, m_bub;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic model_step();
        logic [31:0] n_pc, n_dinst, n_dpc4;
        logic        n_dv, n_xmr, n_xv;
        logic [CTRL_W-1:0] n_xctrl;
        logic [4:0]  n_xrt;
        int          n_mode, n_left;
        bit          frozen;
        frozen = (m_mode == 2);
        if (reset) begin
            m_pc = RESET_PC; m_dinst = 0; m_dpc4 = 0; m_dv = 0;
            m_xctrl = 0; m_xrt = 0; m_xmr = 0; m_xv = 0;
            m_mode = 0; m_left = 0; m_stall = 0; m_bub = 0;
            return;
        end
        n_pc = m_pc; n_dinst = m_dinst; n_dpc4 = m_dpc4; n_dv = m_dv;
        if (!frozen) begin
            if (branch_taken) n_pc = branch_target;
            else if (hazardPCenable) n_pc = m_pc + 32'd4;
            if (branch_taken) begin
                n_dinst = 0; n_dpc4 = 0; n_dv = 0;
            end else if (hazardIFIDenable) begin
                n_dinst = F_instruction; n_dpc4 = m_pc + 32'd4; n_dv = 1;
            end
        end
        if (frozen || branch_taken || hazardIDEXenable) begin
            n_xctrl = 0; n_xrt = 0; n_xmr = 0; n_xv = 0;
        end else begin
            n_xctrl = D_ctrl; n_xrt = D_rt; n_xmr = D_MemRead; n_xv = m_dv;
        end
        n_mode = m_mode; n_left = m_left;
        if (m_mode == 0) begin
            if (m_dv && m_dinst[31:26] == 6'h3f && !branch_taken) begin
                n_mode = 1; n_left = DRAIN_CYCLES;
            end
        end else if (m_mode == 1) begin
            if (branch_taken) n_mode = 0;
            else begin
                n_left = m_left - 1;
                if (n_left == 0) n_mode = 2;
            end
        end
        if (!frozen && !branch_taken) begin
            if (!hazardPCenable && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (hazardIDEXenable && m_bub < 64'hFFFF_FFFF) m_bub++;
        end
        m_pc = n_pc; m_dinst = n_dinst; m_dpc4 = n_dpc4; m_dv = n_dv;
        m_xctrl = n_xctrl; m_xrt = n_xrt; m_xmr = n_xmr; m_xv = n_xv;
        m_mode = n_mode; m_left = n_left;
    endtask

    // One clock: advance the model with the inputs present at the edge,
    // then compare every output a little after the edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("PC", PC, m_pc);
        chk("D_instruction", D_instruction, m_dinst);
        chk("D_pc_plus4", D_pc_plus4, m_dpc4);
        chk("D_valid", {31'd0, D_valid}, {31'd0, m_dv});
        chk("X_ctrl", {16'd0, X_ctrl}, {16'd0, m_xctrl});
        chk("X_rt", {27'd0, X_rt}, {27'd0, m_xrt});
        chk("X_MemRead", {31'd0, X_MemRead}, {31'd0, m_xmr});
        chk("X_valid", {31'd0, X_valid}, {31'd0, m_xv});
        chk("halted", {31'd0, halted}, {31'd0, (m_mode == 2)});
`ifdef PIPE_STALL_STATS_EN
        chk("stall_cycles", stall_cycles, m_stall[31:0]);
        chk("bubble_count", bubble_count, m_bub[31:0]);
`endif
    endtask

    typedef struct packed {
        logic        rst, hpc, hifid, hidex, br;
        logic [31:0] tgt, finst, e_pc;
        logic        e_dv, e_xv, e_h;
    } vec_t;

    function automatic vec_t mk(logic rst, logic hpc, logic hifid, logic hidex, logic br,
                                logic [31:0] tgt, logic [31:0] finst, logic [31:0] e_pc,
                                logic e_dv, logic e_xv, logic e_h);
        vec_t v;
        v.rst = rst; v.hpc = hpc; v.hifid = hifid; v.hidex = hidex; v.br = br;
        v.tgt = tgt; v.finst = finst; v.e_pc = e_pc;
        v.e_dv = e_dv; v.e_xv = e_xv; v.e_h = e_h;
        return v;
    endfunction

    vec_t tbl[23];

    initial begin
        m_pc = 0; m_dinst = 0; m_dpc4 = 0; m_dv = 0; m_xctrl = 0; m_xrt = 0;
        m_xmr = 0; m_xv = 0; m_mode = 0; m_left = 0; m_stall = 0; m_bub = 0;
        reset = 1; hazardPCenable = 0; hazardIFIDenable = 0; hazardIDEXenable = 0;
        branch_taken = 0; branch_target = 0; F_instruction = 0;
        D_ctrl = 16'h00A5; D_rt = 5'd7; D_MemRead = 1'b1;

        //            rst hpc ifd idx br  target         finst          exp PC        dv xv h
        tbl[0]  = mk(1, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0,         0, 0, 0);
        tbl[1]  = mk(0, 1, 1, 0, 0, 32'h0,          32'h1111_0001, 32'h4,         1, 0, 0);
        tbl[2]  = mk(0, 1, 1, 0, 0, 32'h0,          32'h1111_0002, 32'h8,         1, 1, 0);
        tbl[3]  = mk(0, 0, 0, 1, 0, 32'h0,          32'h1111_0003, 32'h8,         1, 0, 0);
        tbl[4]  = mk(0, 1, 1, 0, 0, 32'h0,          32'h1111_0003, 32'hC,         1, 1, 0);
        tbl[5]  = mk(0, 0, 0, 0, 1, 32'h100,        32'h1111_0004, 32'h100,       0, 0, 0);
        tbl[6]  = mk(0, 1, 1, 0, 0, 32'h0,          HALT_I,        32'h104,       1, 0, 0);
        tbl[7]  = mk(0, 0, 0, 1, 0, 32'h0,          32'h0,         32'h104,       1, 0, 0);
        tbl[8]  = mk(0, 0, 0, 1, 0, 32'h0,          32'h0,         32'h104,       1, 0, 0);
        tbl[9]  = mk(0, 0, 0, 1, 0, 32'h0,          32'h0,         32'h104,       1, 0, 0);
        tbl[10] = mk(0, 0, 0, 1, 0, 32'h0,          32'h0,         32'h104,       1, 0, 1);
        tbl[11] = mk(0, 1, 1, 0, 0, 32'h0,          32'h2222_0000, 32'h104,       1, 0, 1);
        tbl[12] = mk(0, 1, 1, 0, 1, 32'h200,        32'h2222_0001, 32'h104,       1, 0, 1);
        tbl[13] = mk(1, 1, 1, 0, 0, 32'h0,          32'h0,         32'h0,         0, 0, 0);
        tbl[14] = mk(0, 1, 1, 0, 0, 32'h0,          HALT_I,        32'h4,         1, 0, 0);
        tbl[15] = mk(0, 1, 1, 0, 0, 32'h0,          32'h0,         32'h8,         1, 1, 0);
        tbl[16] = mk(0, 1, 1, 0, 1, 32'h40,         32'h0,         32'h40,        0, 0, 0);
        tbl[17] = mk(0, 1, 1, 0, 0, 32'h0,          32'h0,         32'h44,        1, 0, 0);
        tbl[18] = mk(0, 1, 1, 0, 0, 32'h0,          32'h0,         32'h48,        1, 1, 0);
        tbl[19] = mk(0, 1, 1, 0, 0, 32'h0,          32'h0,         32'h4C,        1, 1, 0);
        tbl[20] = mk(0, 1, 1, 0, 0, 32'h0,          32'h0,         32'h50,        1, 1, 0);
        tbl[21] = mk(0, 1, 1, 0, 1, 32'hFFFF_FFFC,  32'h0,         32'hFFFF_FFFC, 0, 0, 0);
        tbl[22] = mk(0, 1, 1, 0, 0, 32'h0,          32'h3333_0000, 32'h0,         1, 0, 0);

        for (int i = 0; i < 23; i++) begin
            reset = tbl[i].rst; hazardPCenable = tbl[i].hpc; hazardIFIDenable = tbl[i].hifid;
            hazardIDEXenable = tbl[i].hidex; branch_taken = tbl[i].br;
            branch_target = tbl[i].tgt; F_instruction = tbl[i].finst;
            cycle();
            chk($sformatf("vec%0d PC", i), PC, tbl[i].e_pc);
            chk($sformatf("vec%0d D_valid", i), {31'd0, D_valid}, {31'd0, tbl[i].e_dv});
            chk($sformatf("vec%0d X_valid", i), {31'd0, X_valid}, {31'd0, tbl[i].e_xv});
            chk($sformatf("vec%0d halted", i), {31'd0, halted}, {31'd0, tbl[i].e_h});
        end
        chk("wrap D_pc_plus4", D_pc_plus4, 32'h0);

        // Load-use bubble must clear X_rt and X_MemRead even with a load in D.
        hazardPCenable = 0; hazardIFIDenable = 0; hazardIDEXenable = 1;
        cycle();
        chk("bubble X_rt", {27'd0, X_rt}, 32'd0);
        chk("bubble X_MemRead", {31'd0, X_MemRead}, 32'd0);
        hazardPCenable = 1; hazardIFIDenable = 1; hazardIDEXenable = 0;
        cycle();
        chk("resume X_rt", {27'd0, X_rt}, 32'd7);
        chk("resume X_MemRead", {31'd0, X_MemRead}, 32'd1);

`ifdef PIPE_STALL_STATS_EN
        reset = 1; cycle();
        reset = 0; hazardPCenable = 0; hazardIFIDenable = 0; hazardIDEXenable = 0;
        for (int i = 0; i < 5; i++) cycle();
        chk("stats stall 5", stall_cycles, 32'd5);
        chk("stats bubble 0", bubble_count, 32'd0);
        hazardIDEXenable = 1; cycle();
        chk("stats bubble 1", bubble_count, 32'd1);
`endif

        // Randomized traffic against the model.
        reset = 1; cycle();
        for (int i = 0; i < 600; i++) begin
            reset            = ($urandom_range(0, 79) == 0);
            hazardPCenable   = ($urandom_range(0, 3) != 0);
            hazardIFIDenable = ($urandom_range(0, 3) != 0);
            hazardIDEXenable = ($urandom_range(0, 4) == 0);
            branch_taken     = ($urandom_range(0, 9) == 0);
            branch_target    = {$urandom, 2'b00} & 32'hFFFF_FFFC;
            F_instruction    = ($urandom_range(0, 5) == 0) ? (HALT_I | ($urandom & 32'h03FF_FFFF))
                                                          : ($urandom & 32'hF7FF_FFFF);
            D_ctrl           = CTRL_W'($urandom);
            D_rt             = 5'($urandom);
            D_MemRead        = 1'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
